// File: rtl/muldiv_if.sv
// Handshake and data bundle between the datapath and the multiply/divide unit.
// The master side issues requests and the slave side returns HI/LO and status.
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 iterative multiply/divide unit owning the MIPS HI/LO register pair.
// One shift-add or restoring subtract-shift step per cycle, WIDTH+1 edges of
// latency from the accepting edge to the done pulse.
// Optional build macro: MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which
// accumulate the product into {HI,LO}.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    typedef enum logic [3:0] {
        OP_MULT  = 4'b0000,
        OP_MULTU = 4'b0001,
        OP_DIV   = 4'b0010,
        OP_DIVU  = 4'b0011,
        OP_MTHI  = 4'b0100,
        OP_MTLO  = 4'b0101,
        OP_MADD  = 4'b1000,
        OP_MADDU = 4'b1001,
        OP_MSUB  = 4'b1010,
        OP_MSUBU = 4'b1011
    } op_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   work_hi_q, work_lo_q;   // partial product / remainder:quotient
    logic [WIDTH-1:0]   mag_b_q;                // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_q;                    // raw dividend, returned in HI on divide-by-zero
    logic               div_q, res_neg_q, rem_neg_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;
`ifdef MULDIV_MADD_EN
    logic               acc_q, sub_q;
`endif

    // Request decode
    logic eng_op, op_signed, op_div;
`ifdef MULDIV_MADD_EN
    logic op_acc, op_sub;
`endif
    logic accept, accept_eng;

    // Classify the incoming opcode; reserved codes leave every flag low.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        eng_op    = 1'b0;
        op_signed = 1'b0;
        op_div    = 1'b0;
`ifdef MULDIV_MADD_EN
        op_acc    = 1'b0;
        op_sub    = 1'b0;
`endif
        case (bus.op)
            OP_MULT:  begin eng_op = 1'b1; op_signed = 1'b1; end
            OP_MULTU: begin eng_op = 1'b1; end
            OP_DIV:   begin eng_op = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
            OP_DIVU:  begin eng_op = 1'b1; op_div = 1'b1; end
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin eng_op = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
            OP_MADDU: begin eng_op = 1'b1; op_acc = 1'b1; end
            OP_MSUB:  begin eng_op = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
            OP_MSUBU: begin eng_op = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
            default:  ;
        endcase
    end

    // flush beats start; requests are only seen while idle (including the done cycle).
    assign accept     = (state_q == S_IDLE) && bus.start && !bus.flush;
    assign accept_eng = accept && eng_op;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign a_neg = op_signed && bus.a[WIDTH-1];
    assign b_neg = op_signed && bus.b[WIDTH-1];
    assign mag_a = a_neg ? -bus.a : bus.a;
    assign mag_b = b_neg ? -bus.b : bus.b;

    // One iteration of the engine
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;

    // Shift-add for multiply, restoring subtract-shift for divide.
    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b_q});
        if (div_q) begin
            // Remainder stays below the divisor, so the low WIDTH bits suffice.
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - mag_b_q) : div_shift[WIDTH-1:0];
            step_lo = {work_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
    end

    // Final sign correction and HI/LO selection
    logic [2*WIDTH-1:0] prod, prod_s, fix_pair;
    logic [WIDTH-1:0]   quo, rem;
    logic               dbz_now;

    // Compute the values written into HI/LO in the FIX cycle.
    always_comb begin
        prod    = {work_hi_q, work_lo_q};
        prod_s  = res_neg_q ? -prod : prod;
        quo     = res_neg_q ? -work_lo_q : work_lo_q;
        rem     = rem_neg_q ? -work_hi_q : work_hi_q;
        dbz_now = div_q && (mag_b_q == '0);
        if (div_q) begin
            fix_pair = dbz_now ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
        end else begin
            fix_pair = prod_s;
`ifdef MULDIV_MADD_EN
            if (acc_q) begin
                fix_pair = sub_q ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
            end
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: flush returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_eng) state_d = S_RUN;
            S_RUN:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) state_d = S_IDLE;
    end

    // Output logic: busy covers RUN and FIX; done/dbz/HI/LO are registered.
    always_comb begin
        bus.busy = (state_q != S_IDLE);
        bus.done = done_q;
        bus.dbz  = dbz_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

    // Datapath: operand capture, iteration, result write-back and MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            mag_b_q   <= '0;
            a_q       <= '0;
            div_q     <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q     <= 1'b0;
            sub_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept_eng) begin
                cnt_q     <= CNT_W'(WIDTH - 1);
                work_hi_q <= '0;
                work_lo_q <= mag_a;
                mag_b_q   <= mag_b;
                a_q       <= bus.a;
                div_q     <= op_div;
                res_neg_q <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
`ifdef MULDIV_MADD_EN
                acc_q     <= op_acc;
                sub_q     <= op_sub;
`endif
            end else if (accept && bus.op == OP_MTHI) begin
                hi_q <= bus.a;
            end else if (accept && bus.op == OP_MTLO) begin
                lo_q <= bus.a;
            end

            if (state_q == S_RUN && !bus.flush) begin
                work_hi_q <= step_hi;
                work_lo_q <= step_lo;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end

            if (state_q == S_FIX && !bus.flush) begin
                {hi_q, lo_q} <= fix_pair;
                done_q       <= 1'b1;
                dbz_q        <= dbz_now;
            end
        end
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle, parametrised multiply/divide unit that owns the HI/LO register pair for the MIPS datapath.
- Replaces single-cycle combinational multiply/divide with a radix-2 iterative engine.
- Uses a start/busy/done handshake; the ALU keeps only the HI/LO read path (MFHI/MFLO) from this block's outputs.
- Adds MTHI/MTLO writes, flush on exception, divide-by-zero reporting and correct MIPS signed semantics.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; any value >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  4  0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MTHI, 0101 MTLO; 1000-1011 per Optional Feature; others reserved
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
- b  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  abort any in-flight operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, HI/LO updated
- dbz  out  1  valid with done: the last DIV/DIVU had b=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, dbz=0, hi=0, lo=0; counter=0.
- States: IDLE, RUN, FIX.
- IDLE + start + op in {MULT,MULTU,DIV,DIVU} at edge E0:
  - latch operand magnitudes (signed ops: two's-complement negate if MSB=1) and result sign;
  - go to RUN; busy=1 from E0.
- RUN: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle for exactly WIDTH cycles, counter WIDTH-1 down to 0. RUN->FIX at edge E0+WIDTH.
- FIX, at edge E0+WIDTH+1:
  - apply sign correction and write HI/LO; done=1 and busy=0 for that one cycle; return to IDLE.
  - Total latency: WIDTH+1 edges after the accepting edge.
  - A new start may be sampled in the done cycle.
- Multiply: {HI,LO} = full 2*WIDTH product. Signed uses two's-complement; MULTU is zero-extended.
- Divide:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (a).
  - DIV of most-negative by -1: LO = most-negative, HI = 0; no trap.
- Divide by zero: runs the full latency, then LO = all ones, HI = a (unmodified), dbz=1 with done.
- dbz holds its value until the next done.
- MTHI/MTLO:
  - IDLE + start: write a to hi (or lo) at that edge; no busy, no done.
  - Accepted in the done cycle.
- Reserved op with start: ignored; no state change.
- start while busy=1: ignored; no queuing.
- flush:
  - any state -> IDLE at next edge; busy=0; HI/LO retain prior values; done not asserted.
  - flush and start in the same cycle: flush wins, the request is dropped.
  - flush during the FIX cycle: result discarded.
- Operand inputs are not required to stay stable after the accepting edge.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: ops 1000 MADD, 1001 MADDU, 1010 MSUB, 1011 MSUBU are accepted.
  - The product is computed as for MULT/MULTU.
  - In FIX: {HI,LO} = {HI,LO} +/- product, modulo 2^(2*WIDTH).
  - HI/LO are sampled at the FIX edge, so an MTHI/MTLO cannot intervene because busy=1.
  - Same latency as MULT.
- Undefined: 1000-1011 are reserved and ignored; no accumulator adder is synthesised.

Test Plan (WIDTH=32; latency 33 edges):
- MULT a=0xFFFFFFFE(-2), b=0x00000003 -> done at edge E0+33; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high edges E0..E0+32.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9(-7), b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
- DIVU a=5, b=0 -> dbz=1, lo=0xFFFFFFFF, hi=5.
- MTHI a=0x12345678, then MULT started, then flush at E0+10 -> busy=0 at E0+11, done never pulses, hi=0x12345678.
- With MULDIV_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0.
- start asserted while busy -> request ignored, result unchanged.
